// File: rtl/relm_i2c_master.sv
// rtl/relm_i2c_master.sv - byte-level I2C master behind a ReLM push/pop port pair
// Quarter-bit sequencer with clock-stretch support.
module relm_i2c_master #(
  parameter int WD  = 32,
  parameter int DIV = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [WD:0] push_d,
  output logic        push_retry,
  input  logic [WD:0] pop_d,
  output logic [WD:0] pop_q,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        scl_oe_out,
  output logic        sda_oe_out
);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_BIT, ST_ACK, ST_STOP} state_t;

  localparam logic [15:0] RELOAD = 16'(DIV - 1);
  // The synchroniser already spent two cycles of the quarter, so the hold value
  // is taken two lower to keep Q3 exactly DIV clocks after the pin goes high.
  localparam logic [15:0] HOLD = (DIV > 2) ? 16'(DIV - 3) : 16'd0;

  state_t      state;
  logic [1:0]  q;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic [7:0]  rx;
  logic        rd, nack, stop_pend, skip, busy;
  logic        last_ack, sticky;
  logic        scl_m, scl_s, sda_m, sda_s;
  logic        rel_m, rel_s;

  logic accept, stretched, q_done, set_nack, unused_bits;

  assign accept      = push_d[WD] && !busy;
  // rel_s tracks our own release through the same two-flop delay as scl_s
  assign stretched   = (state != ST_IDLE) && (q == 2'd2) && rel_s && !scl_s;
  assign q_done      = (cnt == 16'd0) && !stretched;
  assign set_nack    = (state == ST_ACK) && (q == 2'd2) && q_done && !rd && sda_s;
  assign push_retry  = busy;
  assign pop_q       = {busy, {(WD-10){1'b0}}, sticky, last_ack, rx};
  assign unused_bits = ^{push_d[WD-1:13], pop_d[WD-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      q          <= 2'd0;
      cnt        <= 16'd0;
      bit_idx    <= 3'd0;
      shreg      <= 8'd0;
      rx         <= 8'd0;
      rd         <= 1'b0;
      nack       <= 1'b0;
      stop_pend  <= 1'b0;
      skip       <= 1'b0;
      busy       <= 1'b0;
      last_ack   <= 1'b0;
      sticky     <= 1'b0;
      scl_m      <= 1'b1;
      scl_s      <= 1'b1;
      sda_m      <= 1'b1;
      sda_s      <= 1'b1;
      rel_m      <= 1'b1;
      rel_s      <= 1'b1;
      scl_oe_out <= 1'b0;
      sda_oe_out <= 1'b0;
    end else begin
      scl_m  <= scl_in;
      scl_s  <= scl_m;
      sda_m  <= sda_in;
      sda_s  <= sda_m;
      rel_m  <= !scl_oe_out;
      rel_s  <= rel_m;
      sticky <= set_nack || (sticky && !pop_d[WD]);

      if (state == ST_IDLE) begin
        busy       <= 1'b0;
        sda_oe_out <= 1'b0;
        if (accept) begin
          busy      <= 1'b1;
          shreg     <= push_d[7:0];
          stop_pend <= push_d[9];
          rd        <= push_d[10];
          nack      <= push_d[11];
          skip      <= push_d[12];
          cnt       <= RELOAD;
          q         <= 2'd0;
          if (push_d[8]) begin
            // bus already released: SCL is high, so skip straight to Q2
            state <= ST_START;
            if (!scl_oe_out) q <= 2'd2;
          end else if (!push_d[12]) begin
            state      <= ST_BIT;
            bit_idx    <= 3'd7;
            scl_oe_out <= 1'b1;
            sda_oe_out <= !push_d[10] && !push_d[7];
          end else if (push_d[9]) begin
            state      <= ST_STOP;
            scl_oe_out <= 1'b1;
            sda_oe_out <= 1'b1;
          end
        end
      end else if (stretched) begin
        cnt <= HOLD;
      end else if (!q_done) begin
        cnt <= cnt - 16'd1;
      end else begin
        cnt <= RELOAD;
        q   <= q + 2'd1;
        case (q)
          2'd1: scl_oe_out <= 1'b0;
          2'd2: begin
            case (state)
              ST_START: sda_oe_out <= 1'b1;
              ST_STOP:  sda_oe_out <= 1'b0;
              ST_BIT:   if (rd) shreg <= {shreg[6:0], sda_s};
              ST_ACK: begin
                last_ack <= rd ? nack : sda_s;
                if (rd) rx <= shreg;
              end
              default: ;
            endcase
          end
          2'd3: begin
            case (state)
              ST_START: begin
                if (!skip) begin
                  state      <= ST_BIT;
                  bit_idx    <= 3'd7;
                  scl_oe_out <= 1'b1;
                  sda_oe_out <= !rd && !shreg[7];
                end else if (stop_pend) begin
                  state      <= ST_STOP;
                  scl_oe_out <= 1'b1;
                  sda_oe_out <= 1'b1;
                end else begin
                  state      <= ST_IDLE;
                  scl_oe_out <= 1'b1;
                  busy       <= 1'b0;
                end
              end
              ST_BIT: begin
                scl_oe_out <= 1'b1;
                if (bit_idx != 3'd0) begin
                  bit_idx    <= bit_idx - 3'd1;
                  sda_oe_out <= !rd && !shreg[bit_idx - 3'd1];
                end else begin
                  state      <= ST_ACK;
                  sda_oe_out <= rd && !nack;
                end
              end
              ST_ACK: begin
                scl_oe_out <= 1'b1;
                if (stop_pend) begin
                  state      <= ST_STOP;
                  sda_oe_out <= 1'b1;
                end else begin
                  // keep the bus: SCL parked low, SDA freed on the next idle cycle
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                end
              end
              default: begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule
